// File: rtl/stack_pointer.sv
// 8-bit stack pointer for the TTM4 emulator datapath: steps up/down on each
// falling edge of the SPC strobe, or loads its low nibble from STOREBUS.
module stack_pointer #(
  parameter int unsigned             SP_W   = 8,
  parameter int unsigned             BUS_W  = 4,
  parameter logic [SP_W-1:0]         SP_RST = 8'hFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             nSK_EN,
  input  logic             SP_D_nU,
  input  logic             SPC,
  output logic [SP_W-1:0]  SP,
  input  logic [BUS_W-1:0] STOREBUS
);

  localparam logic [SP_W-1:0] ONE = {{(SP_W-1){1'b0}}, 1'b1};

  logic spc_q;
  logic strobe;

  // A strobe is a 1->0 transition of SPC, so holding SPC low acts only once.
  assign strobe = spc_q & ~SPC;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SP    <= SP_RST;
      spc_q <= 1'b1;
    end else begin
      spc_q <= SPC;
      if (strobe) begin
        if (!nSK_EN) begin
          SP <= SP_D_nU ? (SP - ONE) : (SP + ONE);
        end else begin
          SP[BUS_W-1:0] <= STOREBUS;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_pointer.sv
// Directed bench for stack_pointer: reset, counting, wrap, nibble load and
// reset arriving in the middle of a strobe.
module tb_stack_pointer;

  logic       tb_CLK;
  logic       tb_RST;
  logic       tb_nSK_EN;
  logic       tb_SP_D_nU;
  logic       tb_SPC;
  logic [7:0] tb_SP;
  logic [3:0] tb_STOREBUS;

  int checks = 0;
  int errors = 0;

  stack_pointer #(
    .SP_W  (8),
    .BUS_W (4),
    .SP_RST(8'hFF)
  ) dut (
    .CLK     (tb_CLK),
    .RST     (tb_RST),
    .nSK_EN  (tb_nSK_EN),
    .SP_D_nU (tb_SP_D_nU),
    .SPC     (tb_SPC),
    .SP      (tb_SP),
    .STOREBUS(tb_STOREBUS)
  );

  initial begin
    tb_CLK = 1'b0;
    forever #5 tb_CLK = ~tb_CLK;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge tb_CLK);
    #1;
  endtask

  task automatic check_sp(input string tag, input logic [7:0] expected);
    checks++;
    assert (tb_SP === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, tb_SP, expected);
    end
  endtask

  initial begin
    tb_RST      = 1'b1;
    tb_SPC      = 1'b1;
    tb_nSK_EN   = 1'b0;
    tb_SP_D_nU  = 1'b1;
    tb_STOREBUS = 4'h0;
    #1;
    check_sp("reset_async", 8'hFF);

    // Reset held while the clock runs.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_sp("reset_held", 8'hFF);
    end
    tb_RST = 1'b0;
    tick();
    check_sp("release_idle0", 8'hFF);
    tick();
    check_sp("release_idle1", 8'hFF);

    // Single decrement pulse.
    tb_SPC = 1'b0;
    tick();
    check_sp("dec_pulse", 8'hFE);
    tb_SPC = 1'b1;
    tick();
    check_sp("dec_after0", 8'hFE);
    tick();
    check_sp("dec_after1", 8'hFE);

    // SPC held low for 5 cycles gives one increment.
    tb_SP_D_nU = 1'b0;
    tb_SPC     = 1'b0;
    tick();
    check_sp("inc_long_first", 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_sp("inc_long_hold", 8'hFF);
    end
    tb_SPC = 1'b1;
    tick();
    check_sp("inc_rearm", 8'hFF);
    tb_SPC = 1'b0;
    tick();
    check_sp("inc_wrap", 8'h00);
    tb_SPC = 1'b1;
    tick();

    // Underflow wrap.
    tb_SP_D_nU = 1'b1;
    tb_SPC     = 1'b0;
    tick();
    check_sp("dec_wrap", 8'hFF);
    tb_SPC = 1'b1;
    tick();
    tb_SPC = 1'b0;
    tick();
    check_sp("dec_to_fe", 8'hFE);
    tb_SPC = 1'b1;
    tick();

    // Nibble load keeps the upper bits.
    tb_nSK_EN   = 1'b1;
    tb_STOREBUS = 4'h5;
    tb_SPC      = 1'b0;
    tick();
    check_sp("load_nibble", 8'hF5);
    tb_SPC = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_STOREBUS = 4'(i * 3 + 7);
      tb_nSK_EN   = i[0];
      tb_SP_D_nU  = i[1];
      tick();
      check_sp("load_hold", 8'hF5);
    end

    // Increment from a non-wrapping value.
    tb_nSK_EN  = 1'b0;
    tb_SP_D_nU = 1'b0;
    tb_SPC     = 1'b0;
    tick();
    check_sp("inc_mid", 8'hF6);
    tb_SPC = 1'b1;
    tick();

    // Reset arrives mid-cycle during a low SPC pulse.
    tb_SP_D_nU = 1'b1;
    tb_SPC     = 1'b0;
    tick();
    check_sp("dec_before_rst", 8'hF5);
    #2;
    tb_RST = 1'b1;
    #1;
    check_sp("rst_mid_strobe", 8'hFF);
    @(negedge tb_CLK);
    tb_RST = 1'b0;
    tick();
    check_sp("rst_release_step", 8'hFE);
    tick();
    check_sp("rst_release_hold", 8'hFE);
    tb_SPC = 1'b1;
    tick();
    check_sp("final_idle", 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
